// File: rtl/sqrt_csr_accel_if.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_csr_accel_if
// Description : UDM bus request/response bundle between the address decode
//               (master) and the square-root accelerator register window
//               (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface sqrt_csr_accel_if;
  logic        bus_req_i;
  logic        bus_we_i;
  logic [31:0] bus_addr_bi;
  logic [3:0]  bus_be_bi;
  logic [31:0] bus_wdata_bi;
  logic        bus_ack_o;
  logic        bus_resp_o;
  logic [31:0] bus_rdata_bo;

  modport master (
    output bus_req_i, bus_we_i, bus_addr_bi, bus_be_bi, bus_wdata_bi,
    input  bus_ack_o, bus_resp_o, bus_rdata_bo
  );

  modport slave (
    input  bus_req_i, bus_we_i, bus_addr_bi, bus_be_bi, bus_wdata_bi,
    output bus_ack_o, bus_resp_o, bus_rdata_bo
  );
endinterface
`default_nettype wire

// File: rtl/sqrt_csr_accel.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_csr_accel
// Description : Memory-mapped iterative integer square root. A restoring
//               engine consumes 2 radicand bits per cycle over 16 steps and
//               publishes the 16-bit root and 17-bit remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module sqrt_csr_accel #(
  parameter logic [31:0] BASE_ADDR = 32'h80001000,
  parameter int unsigned ITER      = 16
) (
  input  wire logic       clk_gen,
  input  wire logic       srst,
  sqrt_csr_accel_if.slave bus,
  output logic            irq_o
);

  localparam logic [4:0]  c_last_iter = 5'(ITER - 1);
  localparam logic [31:0] c_win_bytes = 32'h0000_0014;
  localparam logic [2:0]  c_w_operand = 3'd0;
  localparam logic [2:0]  c_w_ctrl    = 3'd1;
  localparam logic [2:0]  c_w_root    = 3'd2;
  localparam logic [2:0]  c_w_rem     = 3'd3;
  localparam logic [2:0]  c_w_count   = 3'd4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_operand;
  logic [31:0] r_rad;
  logic [15:0] r_wroot;
  logic [17:0] r_wrem;
  logic [4:0]  r_iter;
  logic [15:0] r_root;
  logic [16:0] r_rem;
  logic [31:0] r_count;
  logic        r_done;
  logic        r_err;
  logic        r_ien;
  logic        r_resp;
  logic [31:0] r_rdata;

  // Address decode: offset relative to the window, word aligned only.
  logic [31:0] w_off;
  logic [2:0]  w_word;
  logic        w_hit;
  logic        w_wr;
  logic        w_rd;
  assign w_off  = bus.bus_addr_bi - BASE_ADDR;
  assign w_word = w_off[4:2];
  assign w_hit  = bus.bus_req_i && (w_off < c_win_bytes) && (w_off[1:0] == 2'b00);
  assign w_wr   = w_hit && bus.bus_we_i;
  assign w_rd   = w_hit && !bus.bus_we_i;

  // Control register write strobes; all control bits live in byte lane 0.
  logic w_ctrl_wr;
  logic w_start_req;
  logic w_start;
  logic w_start_bad;
  assign w_ctrl_wr   = w_wr && (w_word == c_w_ctrl) && bus.bus_be_bi[0];
  assign w_start_req = w_ctrl_wr && bus.bus_wdata_bi[0];
  assign w_start     = w_start_req && (r_state == IDLE);
  assign w_start_bad = w_start_req && (r_state == RUN);

  // One restoring step. The work remainder never exceeds 2*root, so only its
  // low 16 bits matter when shifted into the 18-bit trial value.
  logic [17:0] w_trial;
  logic [17:0] w_sub;
  logic        w_fits;
  logic [17:0] w_rem_nxt;
  logic [15:0] w_root_nxt;
  logic        w_last;
  logic        w_unused;
  assign w_trial    = {r_wrem[15:0], r_rad[31:30]};
  assign w_sub      = {r_wroot, 2'b01};
  assign w_fits     = (w_trial >= w_sub);
  assign w_rem_nxt  = w_fits ? (w_trial - w_sub) : w_trial;
  assign w_root_nxt = {r_wroot[14:0], w_fits};
  assign w_last     = (r_iter == c_last_iter);
  assign w_unused   = ^{r_wrem[17:16], r_wroot[15], w_rem_nxt[17]};

  logic w_busy;
  assign w_busy = (r_state == RUN);

  // Sequencer: latch the operand on start, iterate, publish results on exit.
  always_ff @(posedge clk_gen) begin
    if (srst) begin
      r_state <= IDLE;
      r_rad   <= '0;
      r_wroot <= '0;
      r_wrem  <= '0;
      r_iter  <= '0;
      r_root  <= '0;
      r_rem   <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_rad   <= r_operand;
            r_wroot <= '0;
            r_wrem  <= '0;
            r_iter  <= '0;
            r_done  <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_rad   <= {r_rad[29:0], 2'b00};
          r_wroot <= w_root_nxt;
          r_wrem  <= w_rem_nxt;
          r_iter  <= r_iter + 5'd1;
          if (w_last) begin
            r_root  <= w_root_nxt;
            r_rem   <= w_rem_nxt[16:0];
            r_count <= r_count + 32'd1;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Software-visible CSRs: operand bytes, interrupt enable, sticky error.
  always_ff @(posedge clk_gen) begin
    if (srst) begin
      r_operand <= '0;
      r_ien     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_wr && (w_word == c_w_operand)) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.bus_be_bi[b]) r_operand[8*b +: 8] <= bus.bus_wdata_bi[8*b +: 8];
        end
      end
      if (w_ctrl_wr) r_ien <= bus.bus_wdata_bi[3];
      // A rejected start outranks a simultaneous clear.
      if (w_start_bad) r_err <= 1'b1;
      else if (w_ctrl_wr && bus.bus_wdata_bi[2]) r_err <= 1'b0;
    end
  end

  // Read data selection for the addressed word.
  logic [31:0] w_rdata;
  always_comb begin
    w_rdata = '0;
    case (w_word)
      c_w_operand: w_rdata = r_operand;
      c_w_ctrl:    w_rdata = {28'd0, r_ien, r_err, r_done, w_busy};
      c_w_root:    w_rdata = {16'd0, r_root};
      c_w_rem:     w_rdata = {15'd0, r_rem};
      c_w_count:   w_rdata = r_count;
      default:     w_rdata = '0;
    endcase
  end

  // Registered read response, one cycle after acceptance; data is 0 otherwise.
  always_ff @(posedge clk_gen) begin
    if (srst) begin
      r_resp  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_resp  <= w_rd;
      r_rdata <= w_rd ? w_rdata : 32'd0;
    end
  end

  assign bus.bus_ack_o    = bus.bus_req_i;
  assign bus.bus_resp_o   = r_resp;
  assign bus.bus_rdata_bo = r_rdata;
  assign irq_o            = r_done & r_ien;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_csr_accel.sv
`default_nettype none
// ============================================================================
// Module      : tb_sqrt_csr_accel
// Description : Directed self-checking bench for the square-root accelerator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sqrt_csr_accel;

  localparam logic [31:0] c_base = 32'h80001000;

  logic clk_gen = 1'b0;
  logic srst;
  logic irq_o;
  int   checks   = 0;
  int   failures = 0;

  sqrt_csr_accel_if bus ();

  sqrt_csr_accel #(
    .BASE_ADDR (c_base),
    .ITER      (16)
  ) dut (
    .clk_gen (clk_gen),
    .srst    (srst),
    .bus     (bus),
    .irq_o   (irq_o)
  );

  always #5 clk_gen = ~clk_gen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one write in the current cycle; returns at the next negedge.
  task automatic wr(input logic [31:0] off, input logic [31:0] data, input logic [3:0] be);
    bus.bus_req_i    = 1'b1;
    bus.bus_we_i     = 1'b1;
    bus.bus_addr_bi  = c_base + off;
    bus.bus_be_bi    = be;
    bus.bus_wdata_bi = data;
    @(negedge clk_gen);
    bus.bus_req_i    = 1'b0;
    bus.bus_we_i     = 1'b0;
  endtask

  // Drives one read and checks the response one cycle later.
  task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
    bus.bus_req_i   = 1'b1;
    bus.bus_we_i    = 1'b0;
    bus.bus_addr_bi = c_base + off;
    bus.bus_be_bi   = 4'h0;
    #1;
    check({tag, "_ack"}, {31'd0, bus.bus_ack_o}, 32'd1);
    @(negedge clk_gen);
    bus.bus_req_i   = 1'b0;
    check({tag, "_resp"}, {31'd0, bus.bus_resp_o}, 32'd1);
    check(tag, bus.bus_rdata_bo, exp);
  endtask

  // Read that must not hit the window.
  task automatic rd_miss(input string tag, input logic [31:0] off);
    bus.bus_req_i   = 1'b1;
    bus.bus_we_i    = 1'b0;
    bus.bus_addr_bi = c_base + off;
    @(negedge clk_gen);
    bus.bus_req_i   = 1'b0;
    check({tag, "_resp"}, {31'd0, bus.bus_resp_o}, 32'd0);
    check({tag, "_data"}, bus.bus_rdata_bo, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_gen);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    srst             = 1'b1;
    bus.bus_req_i    = 1'b0;
    bus.bus_we_i     = 1'b0;
    bus.bus_addr_bi  = '0;
    bus.bus_be_bi    = '0;
    bus.bus_wdata_bi = '0;
    idle(3);
    srst = 1'b0;

    // Reset state
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    check("rst_resp", {31'd0, bus.bus_resp_o}, 32'd0);
    rd("rst_status", 32'h04, 32'h0);
    rd("rst_operand", 32'h00, 32'h0);
    rd("rst_root", 32'h08, 32'h0);
    rd("rst_rem", 32'h0C, 32'h0);
    rd("rst_count", 32'h10, 32'h0);

    // Zero operand with exact busy window
    wr(32'h00, 32'h0, 4'hF);
    wr(32'h04, 32'h1, 4'h1);
    for (int i = 0; i < 16; i++) rd("busy_window", 32'h04, 32'h1);
    rd("zero_status", 32'h04, 32'h2);
    rd("zero_root", 32'h08, 32'h0);
    rd("zero_rem", 32'h0C, 32'h0);
    rd("zero_count", 32'h10, 32'h1);

    // Largest radicand
    wr(32'h00, 32'hFFFF_FFFF, 4'hF);
    wr(32'h04, 32'h1, 4'h1);
    idle(18);
    rd("max_root", 32'h08, 32'h0000_FFFF);
    rd("max_rem", 32'h0C, 32'h0001_FFFE);
    rd("max_count", 32'h10, 32'h2);

    // Perfect square, then a non-square
    wr(32'h00, 32'd1000000, 4'hF);
    wr(32'h04, 32'h1, 4'h1);
    idle(18);
    rd("m_root", 32'h08, 32'd1000);
    rd("m_rem", 32'h0C, 32'd0);
    wr(32'h00, 32'd99, 4'hF);
    wr(32'h04, 32'h1, 4'h1);
    rd("prev_root_busy", 32'h08, 32'd1000);
    idle(17);
    rd("n99_root", 32'h08, 32'd9);
    rd("n99_rem", 32'h0C, 32'd18);
    rd("n99_count", 32'h10, 32'd4);

    // Start while busy, operand rewritten mid-run
    wr(32'h00, 32'd50, 4'hF);
    wr(32'h04, 32'h1, 4'h1);
    wr(32'h00, 32'd100, 4'hF);
    idle(3);
    wr(32'h04, 32'h1, 4'h1);
    rd("dbl_status_busy", 32'h04, 32'h5);
    idle(15);
    rd("dbl_status_done", 32'h04, 32'h6);
    rd("dbl_root", 32'h08, 32'd7);
    rd("dbl_rem", 32'h0C, 32'd1);
    rd("dbl_count", 32'h10, 32'd5);
    rd("dbl_operand", 32'h00, 32'd100);
    wr(32'h04, 32'h4, 4'h1);
    rd("err_cleared", 32'h04, 32'h2);

    // Start plus err-clear on the final run cycle: error set wins
    wr(32'h04, 32'h1, 4'h1);
    idle(15);
    wr(32'h04, 32'h5, 4'h1);
    rd("last_cycle_status", 32'h04, 32'h6);
    rd("last_cycle_root", 32'h08, 32'd10);
    rd("last_cycle_rem", 32'h0C, 32'd0);
    rd("last_cycle_count", 32'h10, 32'd6);
    wr(32'h04, 32'h4, 4'h1);

    // Interrupt enable and level interrupt
    wr(32'h04, 32'h8, 4'h1);
    rd("ien_status", 32'h04, 32'hA);
    check("irq_on_done", {31'd0, irq_o}, 32'd1);
    wr(32'h00, 32'd144, 4'hF);
    wr(32'h04, 32'h9, 4'h1);
    check("irq_cleared_start", {31'd0, irq_o}, 32'd0);
    idle(16);
    check("irq_completion", {31'd0, irq_o}, 32'd1);
    rd("irq_root", 32'h08, 32'd12);
    rd("irq_count", 32'h10, 32'd7);
    wr(32'h04, 32'h0, 4'b0010);
    rd("be0_off_status", 32'h04, 32'hA);
    wr(32'h04, 32'h0, 4'h1);
    check("irq_ien_off", {31'd0, irq_o}, 32'd0);

    // Decode: misses and read-only words
    rd_miss("miss_0x14", 32'h14);
    rd_miss("miss_unaligned", 32'h02);
    wr(32'h08, 32'h1234, 4'hF);
    rd("root_ro", 32'h08, 32'd12);

    // Reset during a run aborts without counting
    wr(32'h00, 32'd100, 4'hF);
    wr(32'h04, 32'h9, 4'h1);
    idle(7);
    srst = 1'b1;
    @(negedge clk_gen);
    srst = 1'b0;
    check("srst_resp", {31'd0, bus.bus_resp_o}, 32'd0);
    check("srst_irq", {31'd0, irq_o}, 32'd0);
    rd("srst_status", 32'h04, 32'h0);
    rd("srst_count", 32'h10, 32'h0);
    rd("srst_root", 32'h08, 32'h0);
    rd("srst_rem", 32'h0C, 32'h0);
    rd("srst_operand", 32'h00, 32'h0);
    idle(20);
    rd("srst_status_later", 32'h04, 32'h0);
    rd("srst_count_later", 32'h10, 32'h0);

    // Byte enables on the operand
    wr(32'h00, 32'hAABB_CCDD, 4'b0011);
    rd("be_low", 32'h00, 32'h0000_CCDD);
    wr(32'h00, 32'h1122_3344, 4'b1100);
    rd("be_high", 32'h00, 32'h1122_CCDD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
